// File: rtl/dpram_arbiter_pkg.sv
// Shared definitions for controllers that share one dpram between several requesters:
// requester-id width helper and the read-return tag record.
package dpram_arbiter_pkg;

    localparam int unsigned TAG_ID_W = 8;

    typedef struct packed {
        logic                rd;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    function automatic int unsigned req_idw(input int unsigned n);
        int unsigned w;
        w = 1;
        for (int unsigned k = 1; k < 32; k++) begin
            if ((32'd1 << w) < n) w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/dpram.sv
// True dual-port RAM with one registered read output per port.
module dpram #(
    parameter int unsigned AWIDTH    = 10,
    parameter int unsigned NUM_WORDS = 1024,
    parameter int unsigned DWIDTH    = 32
) (
    input  logic              clk,
    input  logic [AWIDTH-1:0] address_a,
    input  logic [AWIDTH-1:0] address_b,
    input  logic              wren_a,
    input  logic              wren_b,
    input  logic [DWIDTH-1:0] data_a,
    input  logic [DWIDTH-1:0] data_b,
    output logic [DWIDTH-1:0] out_a,
    output logic [DWIDTH-1:0] out_b
);

    logic [DWIDTH-1:0] mem [NUM_WORDS];

    always_ff @(posedge clk) begin
        if (wren_a) mem[address_a] <= data_a;
        if (wren_b) mem[address_b] <= data_b;
        out_a <= mem[address_a];
        out_b <= mem[address_b];
    end

endmodule

// File: rtl/dpram_arbiter_rr_pick.sv
// Rotating-priority find-first: first set bit of mask_i scanning upward from start_i, wrapping.
module rr_pick #(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = 2
) (
    input  logic [N-1:0]   mask_i,
    input  logic [IDW-1:0] start_i,
    output logic [N-1:0]   onehot_o,
    output logic [IDW-1:0] idx_o,
    output logic           found_o
);

    logic [IDW-1:0] cand;

    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        found_o  = 1'b0;
        cand     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = IDW'((32'(start_i) + k) % N);
            if (!found_o && mask_i[cand]) begin
                found_o        = 1'b1;
                onehot_o[cand] = 1'b1;
                idx_o          = cand;
            end
        end
    end

endmodule

// File: rtl/dpram_arbiter.sv
// Round-robin arbiter granting up to two requests per cycle onto the two ports of a shared dpram,
// returning read data to the issuing requester two cycles after the grant.
module dpram_arbiter
    import dpram_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned AWIDTH    = 10,
    parameter int unsigned NUM_WORDS = 1024,
    parameter int unsigned DWIDTH    = 32
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_wr,
    input  logic [NUM_REQ*AWIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DWIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [NUM_REQ*DWIDTH-1:0] rsp_data
);

    localparam int unsigned IDW = req_idw(NUM_REQ);

    logic [AWIDTH-1:0]  addr_arr  [NUM_REQ];
    logic [DWIDTH-1:0]  wdata_arr [NUM_REQ];
    logic [NUM_REQ-1:0] g1_oh, g2_oh, mask2;
    logic [IDW-1:0]     g1_idx, g2_idx, start2;
    logic               g1_found, g2_found;
    logic [IDW-1:0]     ptr_q, ptr_d;

    logic [AWIDTH-1:0]  address_a, address_b;
    logic [DWIDTH-1:0]  data_a, data_b, out_a, out_b;
    logic               wren_a, wren_b;

    tag_t               tag_a_q, tag_a_d, tag_b_q, tag_b_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DWIDTH-1:0]  rsp_data_q [NUM_REQ];
    logic [DWIDTH-1:0]  rsp_data_d [NUM_REQ];

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            addr_arr[i]  = req_addr[i*AWIDTH +: AWIDTH];
            wdata_arr[i] = req_wdata[i*DWIDTH +: DWIDTH];
        end
    end

    rr_pick #(.N(NUM_REQ), .IDW(IDW)) u_pick_a (
        .mask_i   (req_valid),
        .start_i  (ptr_q),
        .onehot_o (g1_oh),
        .idx_o    (g1_idx),
        .found_o  (g1_found)
    );

    // Port B candidates: everything valid except grant 1 and anything hazarding with it.
    always_comb begin
        mask2  = '0;
        start2 = IDW'((32'(g1_idx) + 1) % NUM_REQ);
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            mask2[i] = req_valid[i] && !g1_oh[i] &&
                       !((addr_arr[i] == addr_arr[g1_idx]) && (req_wr[i] || req_wr[g1_idx]));
        end
    end

    rr_pick #(.N(NUM_REQ), .IDW(IDW)) u_pick_b (
        .mask_i   (mask2),
        .start_i  (start2),
        .onehot_o (g2_oh),
        .idx_o    (g2_idx),
        .found_o  (g2_found)
    );

    assign req_ready = g1_oh | g2_oh;

    always_comb begin
        ptr_d     = ptr_q;
        wren_a    = 1'b0;
        address_a = '0;
        data_a    = '0;
        wren_b    = 1'b0;
        address_b = '0;
        data_b    = '0;
        tag_a_d   = '0;
        tag_b_d   = '0;
        if (g1_found) begin
            ptr_d      = start2;
            wren_a     = req_wr[g1_idx];
            address_a  = addr_arr[g1_idx];
            data_a     = wdata_arr[g1_idx];
            tag_a_d.rd = !req_wr[g1_idx];
            tag_a_d.id = TAG_ID_W'(g1_idx);
        end
        if (g2_found) begin
            ptr_d      = IDW'((32'(g2_idx) + 1) % NUM_REQ);
            wren_b     = req_wr[g2_idx];
            address_b  = addr_arr[g2_idx];
            data_b     = wdata_arr[g2_idx];
            tag_b_d.rd = !req_wr[g2_idx];
            tag_b_d.id = TAG_ID_W'(g2_idx);
        end
    end

    dpram #(.AWIDTH(AWIDTH), .NUM_WORDS(NUM_WORDS), .DWIDTH(DWIDTH)) u_ram (
        .clk       (clk),
        .address_a (address_a),
        .address_b (address_b),
        .wren_a    (wren_a),
        .wren_b    (wren_b),
        .data_a    (data_a),
        .data_b    (data_b),
        .out_a     (out_a),
        .out_b     (out_b)
    );

    always_comb begin
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        if (tag_a_q.rd) begin
            rsp_valid_d[tag_a_q.id[IDW-1:0]] = 1'b1;
            rsp_data_d[tag_a_q.id[IDW-1:0]]  = out_a;
        end
        if (tag_b_q.rd) begin
            rsp_valid_d[tag_b_q.id[IDW-1:0]] = 1'b1;
            rsp_data_d[tag_b_q.id[IDW-1:0]]  = out_b;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr_q       <= '0;
            tag_a_q     <= '0;
            tag_b_q     <= '0;
            rsp_valid_q <= '0;
            for (int unsigned i = 0; i < NUM_REQ; i++) rsp_data_q[i] <= '0;
        end else begin
            ptr_q       <= ptr_d;
            tag_a_q     <= tag_a_d;
            tag_b_q     <= tag_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) rsp_data[i*DWIDTH +: DWIDTH] = rsp_data_q[i];
    end

endmodule
